// File: rtl/store_merge.sv
// Store merge unit: turns byte/half/word stores into aligned word read-modify-write sequences.
// Latency: word store writes one cycle after acceptance; byte/half read, merge, then write (3 cycles).
// Backpressure: req_ready is high only in IDLE; one request in flight. Optional trap: MISALIGN_TRAP_EN.
module store_merge #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   input  logic [1:0]        req_size,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   input  logic [31:0]       mem_rdata,
   output logic              mem_wr,
   output logic [31:0]       mem_wdata,
   output logic              done,
   output logic              misalign
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RD    = 2'd1;
   localparam logic [1:0] S_MERGE = 2'd2;
   localparam logic [1:0] S_WR    = 2'd3;

   logic [1:0]        state_q,     state_d;
   logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
   logic [31:0]       mem_wdata_q, mem_wdata_d;
   logic              mem_rd_q,    mem_rd_d;
   logic              mem_wr_q,    mem_wr_d;
   logic              done_q,      done_d;
   // Only the narrow-store lane, low data half and size are needed after acceptance;
   // word stores forward req_wdata straight into mem_wdata at the accept edge.
   logic [1:0]        lane_q,      lane_d;
   logic [15:0]       wdata_q,     wdata_d;
   logic              half_q,      half_d;

`ifdef MISALIGN_TRAP_EN
   logic              misalign_q,  misalign_d;
   logic              req_trap;

   // Half on an odd byte, or a word not on a word boundary, is trapped instead of stored.
   assign req_trap = ((req_size == 2'b01) && req_addr[0]) ||
                     (req_size[1] && (req_addr[1:0] != 2'b00));
   assign misalign = misalign_q;
`else
   assign misalign = 1'b0;
`endif

   // Replace the addressed byte or halfword of the memory word with the store data.
   function automatic logic [31:0] merge_word(input logic [31:0] old_w,
                                              input logic [15:0] wd,
                                              input logic [1:0]  lane,
                                              input logic        half);
      logic [31:0] res;
      if (half) begin
         res = lane[1] ? {wd, old_w[15:0]} : {old_w[31:16], wd};
      end else begin
         case (lane)
            2'd0:    res = {old_w[31:8], wd[7:0]};
            2'd1:    res = {old_w[31:16], wd[7:0], old_w[7:0]};
            2'd2:    res = {old_w[31:24], wd[7:0], old_w[15:0]};
            default: res = {wd[7:0], old_w[23:0]};
         endcase
      end
      return res;
   endfunction

   // Next-state and next-output computation; strobes default low so they pulse for one cycle.
   always_comb begin
      state_d     = state_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_rd_d    = 1'b0;
      mem_wr_d    = 1'b0;
      done_d      = 1'b0;
      lane_d      = lane_q;
      wdata_d     = wdata_q;
      half_d      = half_q;
`ifdef MISALIGN_TRAP_EN
      misalign_d  = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               mem_addr_d = {req_addr[ADDR_W-1:2], 2'b00};
               lane_d     = req_addr[1:0];
               wdata_d    = req_wdata[15:0];
               half_d     = (req_size == 2'b01);
`ifdef MISALIGN_TRAP_EN
               if (req_trap) begin
                  // Pass through WR without a strobe so req_ready drops for one cycle.
                  state_d    = S_WR;
                  misalign_d = 1'b1;
                  done_d     = 1'b1;
               end else
`endif
               if (req_size[1]) begin
                  state_d     = S_WR;
                  mem_wr_d    = 1'b1;
                  mem_wdata_d = req_wdata;
                  done_d      = 1'b1;
               end else begin
                  state_d  = S_RD;
                  mem_rd_d = 1'b1;
               end
            end
         end
         S_RD: begin
            state_d = S_MERGE;
         end
         S_MERGE: begin
            // mem_rdata is valid this cycle, one cycle after the read strobe.
            mem_wdata_d = merge_word(mem_rdata, wdata_q, lane_q, half_q);
            mem_wr_d    = 1'b1;
            done_d      = 1'b1;
            state_d     = S_WR;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers; reset aborts any request in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_rd_q    <= 1'b0;
         mem_wr_q    <= 1'b0;
         done_q      <= 1'b0;
         lane_q      <= '0;
         wdata_q     <= '0;
         half_q      <= 1'b0;
`ifdef MISALIGN_TRAP_EN
         misalign_q  <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_rd_q    <= mem_rd_d;
         mem_wr_q    <= mem_wr_d;
         done_q      <= done_d;
         lane_q      <= lane_d;
         wdata_q     <= wdata_d;
         half_q      <= half_d;
`ifdef MISALIGN_TRAP_EN
         misalign_q  <= misalign_d;
`endif
      end
   end

   assign req_ready = (state_q == S_IDLE);
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_rd    = mem_rd_q;
   assign mem_wr    = mem_wr_q;
   assign done      = done_q;

endmodule

// File: tb/tb_store_merge.sv
// Directed bench for store_merge: word, byte, half, back-to-back, reset abort, misalignment.
// Inputs driven and outputs sampled 1 time unit after each rising edge.
// Memory model returns a fixed word only in the cycle after mem_rd, garbage otherwise.
module tb_store_merge;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [1:0]  req_size;
   logic [31:0] mem_addr;
   logic        mem_rd;
   logic [31:0] mem_rdata = 32'h0;
   logic        mem_wr;
   logic [31:0] mem_wdata;
   logic        done;
   logic        misalign;

   logic [31:0] tb_word = 32'h1122_3344;
   int          n_tests = 0;
   int          n_fail  = 0;
   int          rd_cnt  = 0;
   int          wr_cnt  = 0;
   int          done_cnt = 0;
   int          rd0, wr0, dn0;

   store_merge #(.ADDR_W(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_size  (req_size),
      .mem_addr  (mem_addr),
      .mem_rd    (mem_rd),
      .mem_rdata (mem_rdata),
      .mem_wr    (mem_wr),
      .mem_wdata (mem_wdata),
      .done      (done),
      .misalign  (misalign)
   );

   always #5 clk = ~clk;

   // Read data appears only in the cycle after the strobe.
   always @(posedge clk) begin
      mem_rdata <= mem_rd ? tb_word : 32'hDEAD_0BAD;
      if (mem_rd === 1'b1) rd_cnt <= rd_cnt + 1;
      if (mem_wr === 1'b1) wr_cnt <= wr_cnt + 1;
      if (done === 1'b1)   done_cnt <= done_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Present a request in the current cycle (T), then scramble inputs; returns in T+1.
   task automatic issue(input string tag, input logic [31:0] a, input logic [1:0] sz,
                        input logic [31:0] wd);
      req_valid = 1'b1;
      req_addr  = a;
      req_size  = sz;
      req_wdata = wd;
      chk({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
      tick;
      req_valid = 1'b0;
      req_addr  = 32'hFFFF_FFFF;
      req_size  = ~sz;
      req_wdata = 32'h0;
   endtask

   initial begin
      // Request presented during reset must be ignored.
      rst       = 1'b1;
      req_valid = 1'b1;
      req_addr  = 32'h100;
      req_size  = 2'b10;
      req_wdata = 32'h1111_1111;
      tick;
      tick;
      chk("rst_ready",     {31'd0, req_ready}, 32'd1);
      chk("rst_mem_rd",    {31'd0, mem_rd},    32'd0);
      chk("rst_mem_wr",    {31'd0, mem_wr},    32'd0);
      chk("rst_done",      {31'd0, done},      32'd0);
      chk("rst_misalign",  {31'd0, misalign},  32'd0);
      chk("rst_mem_addr",  mem_addr,           32'd0);
      chk("rst_mem_wdata", mem_wdata,          32'd0);
      rst       = 1'b0;
      req_valid = 1'b0;
      tick;
      chk("rst_req_ignored_wr", wr_cnt, 32'd0);
      chk("rst_req_ignored_dn", done_cnt, 32'd0);

      // Word store.
      rd0 = rd_cnt;
      issue("word", 32'h100, 2'b10, 32'hDEAD_BEEF);
      chk("word_wr",    {31'd0, mem_wr},    32'd1);
      chk("word_addr",  mem_addr,           32'h100);
      chk("word_wdata", mem_wdata,          32'hDEAD_BEEF);
      chk("word_done",  {31'd0, done},      32'd1);
      chk("word_busy",  {31'd0, req_ready}, 32'd0);
      tick;
      chk("word_wr_end", {31'd0, mem_wr},   32'd0);
      chk("word_dn_end", {31'd0, done},     32'd0);
      chk("word_no_rd",  rd_cnt - rd0,      32'd0);

      // Byte store, lane 3.
      tb_word = 32'h1122_3344;
      issue("byte", 32'h203, 2'b00, 32'h1234_56AB);
      chk("byte_rd",     {31'd0, mem_rd}, 32'd1);
      chk("byte_rdaddr", mem_addr,        32'h200);
      chk("byte_nowr1",  {31'd0, mem_wr}, 32'd0);
      tick;
      chk("byte_rd_end", {31'd0, mem_rd}, 32'd0);
      chk("byte_nowr2",  {31'd0, mem_wr}, 32'd0);
      chk("byte_nodn2",  {31'd0, done},   32'd0);
      tick;
      chk("byte_wr",     {31'd0, mem_wr}, 32'd1);
      chk("byte_wdata",  mem_wdata,       32'hAB22_3344);
      chk("byte_wraddr", mem_addr,        32'h200);
      chk("byte_done",   {31'd0, done},   32'd1);
      tick;

      // Half store, upper lane, followed immediately by a byte store to lane 1.
      issue("half", 32'h202, 2'b01, 32'hFFFF_CAFE);
      chk("half_rd", {31'd0, mem_rd}, 32'd1);
      tick;
      tick;
      chk("half_wr",    {31'd0, mem_wr}, 32'd1);
      chk("half_wdata", mem_wdata,       32'hCAFE_3344);
      chk("half_done",  {31'd0, done},   32'd1);
      chk("half_busy",  {31'd0, req_ready}, 32'd0);
      tick;
      issue("b2b", 32'h401, 2'b00, 32'h0000_0055);
      chk("b2b_rd",     {31'd0, mem_rd}, 32'd1);
      chk("b2b_rdaddr", mem_addr,        32'h400);
      tick;
      tick;
      chk("b2b_wr",     {31'd0, mem_wr}, 32'd1);
      chk("b2b_wdata",  mem_wdata,       32'h1122_5544);
      tick;

      // Reset in T+2 of a byte store aborts it.
      wr0 = wr_cnt;
      dn0 = done_cnt;
      issue("abort", 32'h203, 2'b00, 32'h0000_00AB);
      tick;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      chk("abort_ready", {31'd0, req_ready}, 32'd1);
      chk("abort_nowr",  {31'd0, mem_wr},    32'd0);
      chk("abort_nodn",  {31'd0, done},      32'd0);
      tick;
      tick;
      tick;
      chk("abort_wr_cnt", wr_cnt - wr0,   32'd0);
      chk("abort_dn_cnt", done_cnt - dn0, 32'd0);

      // Misaligned half and word.
      rd0 = rd_cnt;
      wr0 = wr_cnt;
`ifdef MISALIGN_TRAP_EN
      issue("mis_half", 32'h301, 2'b01, 32'hFFFF_1357);
      chk("mis_half_flag", {31'd0, misalign}, 32'd1);
      chk("mis_half_done", {31'd0, done},     32'd1);
      chk("mis_half_rd",   {31'd0, mem_rd},   32'd0);
      chk("mis_half_wr",   {31'd0, mem_wr},   32'd0);
      tick;
      chk("mis_half_ready", {31'd0, req_ready}, 32'd1);
      chk("mis_half_clear", {31'd0, misalign},  32'd0);
      issue("mis_word", 32'h503, 2'b11, 32'hA5A5_5A5A);
      chk("mis_word_flag", {31'd0, misalign}, 32'd1);
      chk("mis_word_done", {31'd0, done},     32'd1);
      tick;
      tick;
      chk("mis_no_rd", rd_cnt - rd0, 32'd0);
      chk("mis_no_wr", wr_cnt - wr0, 32'd0);
`else
      issue("odd_half", 32'h301, 2'b01, 32'hFFFF_1357);
      chk("odd_half_rd",   {31'd0, mem_rd},   32'd1);
      chk("odd_half_mis",  {31'd0, misalign}, 32'd0);
      tick;
      tick;
      chk("odd_half_wr",    {31'd0, mem_wr}, 32'd1);
      chk("odd_half_addr",  mem_addr,        32'h300);
      chk("odd_half_wdata", mem_wdata,       32'h1122_1357);
      tick;
      issue("odd_word", 32'h503, 2'b11, 32'hA5A5_5A5A);
      chk("odd_word_wr",    {31'd0, mem_wr},   32'd1);
      chk("odd_word_addr",  mem_addr,          32'h500);
      chk("odd_word_wdata", mem_wdata,         32'hA5A5_5A5A);
      chk("odd_word_mis",   {31'd0, misalign}, 32'd0);
      tick;
      tick;
      chk("odd_rd_cnt", rd_cnt - rd0, 32'd1);
      chk("odd_wr_cnt", wr_cnt - wr0, 32'd2);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
